// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding (common to the subtractor and a future serial adder) and the
// default operand width.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } serial_state_e;

    localparam int SERIAL_W_DEFAULT = 8;

endpackage : serial_arith_pkg

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: diff = a - b - bin, with the
// borrow out raised when the subtraction needs to borrow from the next bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH cycles through a
// single full-subtractor cell, with valid/ready handshakes on both sides.
// Optional build macro SERIAL_SUB_OVF_EN adds the signed overflow output ovf.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for an operand pair, in_ready high
// ST_SHIFT | one result bit per cycle, busy high
// ST_DONE  | result presented with out_valid until out_ready
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    serial_state_e    state_q;
    serial_state_e    state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             bq_q;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fs_diff;
    logic             fs_bout;
    logic             last_bit;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q;
    logic             b_msb_q;
    logic             ovf_q;
`endif

    full_subtractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bq_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf        = ovf_q;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial shifting and result/borrow loading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bq_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        bq_q  <= 1'b0;
                        cnt_q <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
`endif
                    end
                end
                ST_SHIFT: begin
                    a_q    <= a_q >> 1;
                    b_q    <= b_q >> 1;
                    diff_q <= {fs_diff, diff_q[WIDTH-1:1]};
                    bq_q   <= fs_bout;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        borrow_q <= fs_bout;
`ifdef SERIAL_SUB_OVF_EN
                        // fs_diff here is the result MSB.
                        ovf_q <= (a_msb_q != b_msb_q) & (fs_diff != a_msb_q);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : serial_subtractor
